// File: rtl/sme_pkg.sv
// Shared constants, character codes and FSM encoding for the string-match-engine feeder.
package sme_pkg;

    localparam int MAX_STR = 32;
    localparam int MAX_PAT = 8;
    localparam int TIMEOUT = 255;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SEND_STR,
        GAP,
        SEND_PAT,
        WAIT_RES,
        FINISH
    } sme_state_e;

    // The string length is irrelevant when the engine keeps its previous string.
    function automatic logic lengths_ok(
        input logic [5:0] slen,
        input logic [3:0] plen,
        input logic       skip,
        input int         max_str,
        input int         max_pat
    );
        logic str_ok;
        logic pat_ok;
        str_ok = skip || ((slen != 6'd0) && (int'(slen) <= max_str));
        pat_ok = (plen != 4'd0) && (int'(plen) <= max_pat);
        return str_ok && pat_ok;
    endfunction

endpackage

// File: rtl/sme_byte_ram.sv
// Byte-wide character buffer: synchronous write, asynchronous read, contents survive reset.
module sme_byte_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sme_feeder.sv
// Streams a stored string and pattern into a string-match engine and captures its answer.
module sme_feeder
    import sme_pkg::*;
#(
    parameter int MAX_STR = sme_pkg::MAX_STR,
    parameter int MAX_PAT = sme_pkg::MAX_PAT,
    parameter int TIMEOUT = sme_pkg::TIMEOUT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic       cfg_sel,
    input  logic [4:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    input  logic       skip_str,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       timeout,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       res_match,
    output logic [4:0] res_index
);

    localparam int SAW = $clog2(MAX_STR);
    localparam int PAW = $clog2(MAX_PAT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    sme_state_e  state_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        timeout_q;
    logic [7:0]  chardata_q;
    logic        isstring_q;
    logic        ispattern_q;
    logic        res_match_q;
    logic [4:0]  res_index_q;
    logic [5:0]  str_cnt_q;
    logic [3:0]  pat_cnt_q;
    logic [7:0]  wait_cnt_q;
    logic [5:0]  str_len_q;
    logic [3:0]  pat_len_q;
    logic        skip_q;

    logic        str_we;
    logic        pat_we;
    logic [7:0]  str_rdata;
    logic [7:0]  pat_rdata;

    // Buffers are frozen for the whole transaction so the streamed data is stable.
    assign str_we = cfg_we & ~busy_q & ~cfg_sel;
    assign pat_we = cfg_we & ~busy_q &  cfg_sel;

    sme_byte_ram #(
        .DEPTH (MAX_STR),
        .AW    (SAW)
    ) u_str_ram (
        .clk   (clk),
        .we    (str_we),
        .waddr (cfg_addr[SAW-1:0]),
        .wdata (cfg_data),
        .raddr (str_cnt_q[SAW-1:0]),
        .rdata (str_rdata)
    );

    sme_byte_ram #(
        .DEPTH (MAX_PAT),
        .AW    (PAW)
    ) u_pat_ram (
        .clk   (clk),
        .we    (pat_we),
        .waddr (cfg_addr[PAW-1:0]),
        .wdata (cfg_data),
        .raddr (pat_cnt_q[PAW-1:0]),
        .rdata (pat_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            chardata_q  <= 8'h00;
            isstring_q  <= 1'b0;
            ispattern_q <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= 5'd0;
            str_cnt_q   <= 6'd0;
            pat_cnt_q   <= 4'd0;
            wait_cnt_q  <= 8'd0;
            str_len_q   <= 6'd0;
            pat_len_q   <= 4'd0;
            skip_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= CHECK;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        timeout_q   <= 1'b0;
                        res_match_q <= 1'b0;
                        res_index_q <= 5'd0;
                        str_len_q   <= str_len;
                        pat_len_q   <= pat_len;
                        skip_q      <= skip_str;
                        str_cnt_q   <= 6'd0;
                        pat_cnt_q   <= 4'd0;
                    end
                end
                CHECK: begin
                    if (!lengths_ok(str_len_q, pat_len_q, skip_q, MAX_STR, MAX_PAT)) begin
                        state_q <= FINISH;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (skip_q) begin
                        state_q <= GAP;
                    end else begin
                        // The read address is already 0, so character 0 is available now.
                        state_q    <= SEND_STR;
                        isstring_q <= 1'b1;
                        chardata_q <= str_rdata;
                        str_cnt_q  <= 6'd1;
                    end
                end
                SEND_STR: begin
                    if (str_cnt_q == str_len_q) begin
                        state_q    <= GAP;
                        isstring_q <= 1'b0;
                        chardata_q <= 8'h00;
                    end else begin
                        chardata_q <= str_rdata;
                        str_cnt_q  <= str_cnt_q + 6'd1;
                    end
                end
                GAP: begin
                    state_q     <= SEND_PAT;
                    ispattern_q <= 1'b1;
                    chardata_q  <= pat_rdata;
                    pat_cnt_q   <= 4'd1;
                end
                SEND_PAT: begin
                    if (pat_cnt_q == pat_len_q) begin
                        state_q     <= WAIT_RES;
                        ispattern_q <= 1'b0;
                        chardata_q  <= 8'h00;
                        wait_cnt_q  <= 8'd0;
                    end else begin
                        chardata_q <= pat_rdata;
                        pat_cnt_q  <= pat_cnt_q + 4'd1;
                    end
                end
                WAIT_RES: begin
                    wait_cnt_q <= wait_cnt_q + 8'd1;
                    // A result on the last allowed cycle still counts as an answer.
                    if (sme_valid) begin
                        state_q     <= FINISH;
                        res_match_q <= sme_match;
                        res_index_q <= sme_match_index;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q     <= FINISH;
                        timeout_q   <= 1'b1;
                        res_match_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign timeout   = timeout_q;
    assign chardata  = chardata_q;
    assign isstring  = isstring_q;
    assign ispattern = ispattern_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: drives transactions, plays the engine, checks streams and results.
module tb_sme_feeder;
    import sme_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_we = 1'b0;
    logic       cfg_sel = 1'b0;
    logic [4:0] cfg_addr = 5'd0;
    logic [7:0] cfg_data = 8'h00;
    logic [5:0] str_len = 6'd0;
    logic [3:0] pat_len = 4'd0;
    logic       skip_str = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic       timeout;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       sme_valid = 1'b0;
    logic       sme_match = 1'b0;
    logic [4:0] sme_match_index = 5'd0;
    logic       res_match;
    logic [4:0] res_index;

    sme_feeder dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_we          (cfg_we),
        .cfg_sel         (cfg_sel),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .str_len         (str_len),
        .pat_len         (pat_len),
        .skip_str        (skip_str),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .timeout         (timeout),
        .chardata        (chardata),
        .isstring        (isstring),
        .ispattern       (ispattern),
        .sme_valid       (sme_valid),
        .sme_match       (sme_match),
        .sme_match_index (sme_match_index),
        .res_match       (res_match),
        .res_index       (res_index)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] str_got [$];
    logic [7:0] pat_got [$];
    logic [7:0] exp_str [$];
    logic [7:0] exp_pat [$];
    int   str_last, pat_first, done_c, wait_c, overlap_n, dirty_n;
    logic busy1, busy_done;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [7:0] data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr[4:0];
        cfg_data = data;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wr_text(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) wr(sel, i, s[i]);
    endtask

    task automatic set_exp(input string s, input string p);
        exp_str.delete();
        exp_pat.delete();
        for (int i = 0; i < s.len(); i++) exp_str.push_back(s[i]);
        for (int i = 0; i < p.len(); i++) exp_pat.push_back(p[i]);
    endtask

    // ans < 0: the engine never answers. disturb adds an early result strobe,
    // a start pulse and a buffer write while the feeder is busy.
    task automatic run(input logic [5:0] slen, input logic [3:0] plen, input logic skip,
                       input int ans, input logic m, input logic [4:0] idx, input bit disturb);
        logic prev_pat;
        str_got.delete();
        pat_got.delete();
        str_last = -1; pat_first = -1; done_c = -1; wait_c = -1;
        overlap_n = 0; dirty_n = 0; busy1 = 1'b0; busy_done = 1'b1;
        prev_pat = 1'b0;
        @(negedge clk);
        str_len = slen; pat_len = plen; skip_str = skip;
        sme_match = m; sme_match_index = idx;
        start = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = 1'b0; sme_valid = 1'b0; cfg_we = 1'b0;
            if (isstring) begin str_got.push_back(chardata); str_last = c; end
            if (ispattern) begin pat_got.push_back(chardata); if (pat_first < 0) pat_first = c; end
            if (isstring && ispattern) overlap_n++;
            if (!isstring && !ispattern && chardata != 8'h00) dirty_n++;
            if (c == 1) busy1 = busy;
            if (prev_pat && !ispattern) wait_c = c;
            prev_pat = ispattern;
            if (done) begin done_c = c; busy_done = busy; break; end
            if (ans >= 0 && wait_c >= 0 && c == wait_c + ans) sme_valid = 1'b1;
            if (disturb && c == 3) sme_valid = 1'b1;
            if (disturb && wait_c >= 0 && c == wait_c + 10) start = 1'b1;
            if (disturb && wait_c >= 0 && c == wait_c + 20) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 5'd0; cfg_data = 8'h58;
            end
        end
    endtask

    task automatic verify(input string tag, input int exp_done, input logic exp_err,
                          input logic exp_to, input logic exp_m, input logic [4:0] exp_idx);
        check({tag, ".done_cycle"}, done_c, exp_done);
        check({tag, ".busy_t1"}, busy1, 1);
        check({tag, ".busy_at_done"}, busy_done, 0);
        check({tag, ".err"}, err, exp_err);
        check({tag, ".timeout"}, timeout, exp_to);
        check({tag, ".res_match"}, res_match, exp_m);
        check({tag, ".res_index"}, res_index, exp_idx);
        check({tag, ".str_count"}, str_got.size(), exp_str.size());
        check({tag, ".pat_count"}, pat_got.size(), exp_pat.size());
        for (int i = 0; i < exp_str.size() && i < str_got.size(); i++)
            check($sformatf("%s.str[%0d]", tag, i), str_got[i], exp_str[i]);
        for (int i = 0; i < exp_pat.size() && i < pat_got.size(); i++)
            check($sformatf("%s.pat[%0d]", tag, i), pat_got[i], exp_pat[i]);
        check({tag, ".overlap"}, overlap_n, 0);
        check({tag, ".idle_chardata"}, dirty_n, 0);
        if (exp_str.size() > 0 && exp_pat.size() > 0)
            check({tag, ".gap"}, pat_first - str_last, 2);
        sme_match = ~exp_m;
        sme_match_index = ~exp_idx;
        repeat (3) @(negedge clk);
        check({tag, ".hold_err"}, err, exp_err);
        check({tag, ".hold_timeout"}, timeout, exp_to);
        check({tag, ".hold_match"}, res_match, exp_m);
        check({tag, ".hold_index"}, res_index, exp_idx);
        check({tag, ".idle_busy"}, busy, 0);
    endtask

    task automatic abort_run();
        int dones;
        @(negedge clk);
        str_len = 6'd11; pat_len = 4'd3; skip_str = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort.mid_isstring", isstring, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort.qualifiers", {isstring, ispattern}, 2'b00);
        check("abort.busy", busy, 0);
        check("abort.chardata", chardata, 0);
        reset = 1'b0;
        dones = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort.no_done", dones, 0);
    endtask

    initial begin
        logic [7:0] full_pat [8];
        full_pat[0] = CH_CARET; full_pat[1] = 8'h61; full_pat[2] = CH_DOT;   full_pat[3] = CH_STAR;
        full_pat[4] = 8'h62;    full_pat[5] = CH_SPACE; full_pat[6] = 8'h63; full_pat[7] = CH_DOLLAR;

        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.err", err, 0);
        check("rst.timeout", timeout, 0);
        check("rst.isstring", isstring, 0);
        check("rst.ispattern", ispattern, 0);
        check("rst.chardata", chardata, 8'h00);
        check("rst.res_match", res_match, 0);
        check("rst.res_index", res_index, 0);

        wr_text(1'b0, "hello world");
        wr_text(1'b1, "wor");

        // Plain transfer, answer 5 cycles into the wait; stray strobe during the string.
        set_exp("hello world", "wor");
        run(6'd11, 4'd3, 1'b0, 5, 1'b1, 5'd6, 1'b1);
        verify("hello", 23, 1'b0, 1'b0, 1'b1, 5'd6);

        // Pattern only; an illegal string length is irrelevant here.
        wr(1'b1, 0, CH_CARET);
        wr(1'b1, 1, 8'h68);
        set_exp("", "^h");
        run(6'd0, 4'd2, 1'b1, 0, 1'b0, 5'd9, 1'b0);
        verify("skip", 6, 1'b0, 1'b0, 1'b0, 5'd9);

        set_exp("", "");
        run(6'd0, 4'd3, 1'b0, 0, 1'b1, 5'd3, 1'b0);
        verify("err_str0", 2, 1'b1, 1'b0, 1'b0, 5'd0);
        run(6'd11, 4'd9, 1'b0, 0, 1'b1, 5'd3, 1'b0);
        verify("err_pat9", 2, 1'b1, 1'b0, 1'b0, 5'd0);
        run(6'd33, 4'd3, 1'b0, 0, 1'b1, 5'd3, 1'b0);
        verify("err_str33", 2, 1'b1, 1'b0, 1'b0, 5'd0);

        // Silent engine; start and a string write during the wait must both be ignored.
        wr_text(1'b1, "wor");
        set_exp("hello world", "wor");
        run(6'd11, 4'd3, 1'b0, -1, 1'b1, 5'd7, 1'b1);
        verify("timeout", 272, 1'b0, 1'b1, 1'b0, 5'd0);

        abort_run();
        set_exp("hello world", "wor");
        run(6'd11, 4'd3, 1'b0, 0, 1'b1, 5'd2, 1'b0);
        verify("rerun", 18, 1'b0, 1'b0, 1'b1, 5'd2);

        // Maximum lengths, answer on the final allowed wait cycle.
        exp_str.delete();
        exp_pat.delete();
        for (int i = 0; i < 32; i++) begin
            wr(1'b0, i, 8'h40 + 8'(i));
            exp_str.push_back(8'h40 + 8'(i));
        end
        for (int i = 0; i < 8; i++) begin
            wr(1'b1, i, full_pat[i]);
            exp_pat.push_back(full_pat[i]);
        end
        run(6'd32, 4'd8, 1'b0, 254, 1'b1, 5'd31, 1'b0);
        verify("full_tie", 298, 1'b0, 1'b0, 1'b1, 5'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/sme_feeder.md
SME_FEEDER -- requirements
Module: sme_feeder

Interface
REQ-001 SHALL have parameter MAX_STR, default 32, maximum string length in characters.
REQ-002 SHALL have parameter MAX_PAT, default 8, maximum pattern length in characters.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles allowed for the engine to answer.
REQ-004 clk  in  1  rising-edge clock for all logic.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_we  in  1  write strobe into the character buffers; ignored while busy=1.
REQ-007 cfg_sel  in  1  buffer select: 0 = string buffer, 1 = pattern buffer.
REQ-008 cfg_addr  in  5  character index; for the pattern buffer only bits [2:0] are used.
REQ-009 cfg_data  in  8  ASCII character written.
REQ-010 str_len  in  6  string length, legal range 1..32; sampled when start is accepted.
REQ-011 pat_len  in  4  pattern length, legal range 1..8; sampled when start is accepted.
REQ-012 skip_str  in  1  1 = resend the pattern only and reuse the string already held by the engine; sampled when start is accepted.
REQ-013 start  in  1  one-cycle request; accepted only in IDLE.
REQ-014 busy  out  1  high from the cycle after start is accepted until done.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 err  out  1  qualified by done; 1 = illegal length, no characters sent.
REQ-017 timeout  out  1  qualified by done; 1 = the engine gave no answer within TIMEOUT cycles.
REQ-018 chardata  out  8  character driven to the engine; 0 whenever isstring and ispattern are both low.
REQ-019 isstring  out  1  string-character qualifier to the engine.
REQ-020 ispattern  out  1  pattern-character qualifier to the engine.
REQ-021 sme_valid  in  1  result strobe from the engine.
REQ-022 sme_match  in  1  match flag from the engine.
REQ-023 sme_match_index  in  5  match position from the engine.
REQ-024 res_match  out  1  captured match flag; qualified by done.
REQ-025 res_index  out  5  captured match index; qualified by done.

Function
REQ-026 The FSM SHALL have exactly the states IDLE, CHECK, SEND_STR, GAP, SEND_PAT, WAIT_RES, FINISH.
REQ-027 When start is accepted in cycle T, the FSM SHALL be in CHECK in T+1, and busy SHALL go high in T+1.
REQ-028 In CHECK, if str_len is 0 or greater than 32 (while skip_str=0), or pat_len is 0 or greater than 8, the FSM SHALL go to FINISH with err=1.
REQ-029 From CHECK with legal lengths, the FSM SHALL go to SEND_STR, or to GAP when skip_str=1.
REQ-030 In SEND_STR, isstring SHALL be high for exactly str_len consecutive cycles, with chardata carrying string[0] through string[str_len-1] in order.
REQ-031 GAP SHALL last exactly 1 cycle, with isstring=0 and ispattern=0, so the engine sees a falling edge before the pattern.
REQ-032 In SEND_PAT, ispattern SHALL be high for exactly pat_len consecutive cycles, with chardata carrying pattern[0] through pattern[pat_len-1] in order.
REQ-033 isstring and ispattern SHALL never be high in the same cycle.
REQ-034 In WAIT_RES, an 8-bit counter SHALL start at 0 on entry and increment every cycle.
REQ-035 In WAIT_RES, the first cycle with sme_valid=1 SHALL capture res_match and res_index and move the FSM to FINISH.
REQ-036 If the WAIT_RES counter reaches TIMEOUT with no sme_valid, the FSM SHALL move to FINISH with timeout=1 and res_match=0.
REQ-037 sme_valid arriving in any state other than WAIT_RES SHALL be ignored.
REQ-038 If sme_valid and the timeout occur in the same cycle, sme_valid SHALL win and timeout SHALL be 0.
REQ-039 In FINISH, done SHALL pulse for 1 cycle, busy SHALL drop in the same cycle, and the FSM SHALL return to IDLE.
REQ-040 A new start SHALL be accepted at the earliest in the cycle after done.
REQ-041 start while busy=1 SHALL be ignored.
REQ-042 cfg_we while busy=1 SHALL be ignored.
REQ-043 err, timeout, res_match and res_index SHALL hold their values until the next accepted start.
REQ-044 Character counters SHALL be 6 bits for the string and 4 bits for the pattern, so counting never wraps inside a legal length.

Reset
REQ-045 On reset, the FSM SHALL go to IDLE.
REQ-046 On reset, busy, done, err, timeout, isstring, ispattern, res_match SHALL be 0, chardata SHALL be 0x00 and res_index SHALL be 0.
REQ-047 Reset SHALL NOT clear the buffer contents.
REQ-048 Reset asserted mid-transfer SHALL drop isstring/ispattern in the next cycle; the aborted transfer SHALL produce no done pulse.

Structure
REQ-049 Package sme_pkg SHALL hold MAX_STR, MAX_PAT, TIMEOUT, the character codes (^ 0x5E, $ 0x24, * 0x2A, . 0x2E, space 0x20) and the FSM state enum.
REQ-050 A single sub-module sme_byte_ram (parameterised depth x 8 bit, synchronous write, combinational read, no reset) SHALL be instantiated twice, once for the string and once for the pattern.

Verification
REQ-051 Write string "hello world" (str_len=11) and pattern "wor" (pat_len=3), then start -> isstring high 11 cycles, 1 gap, ispattern high 3 cycles; a model engine answering match=1, index=6 -> done with res_match=1, res_index=6.
REQ-052 skip_str=1 with pattern "^h" -> no isstring cycles, GAP then ispattern high 2 cycles carrying 0x5E and 0x68.
REQ-053 str_len=0 or pat_len=9 -> done exactly 2 cycles after start, err=1, isstring and ispattern never asserted.
REQ-054 str_len=32 and pat_len=8 -> exactly 32 and 8 qualifier cycles; the last string character is taken from address 31.
REQ-055 Engine never answers -> done with timeout=1 exactly 255 cycles after WAIT_RES entry; start pulsed during the wait is ignored.
REQ-056 Reset during SEND_STR -> qualifiers low next cycle, no done; buffer contents retained, proven by a rerun producing the same character stream.
